// File: rtl/scroll_char_feeder.sv
// Four-digit scrolling hex feeder: scans anodes with blanking dead time and presents the
// character of the enabled digit. Optional AUTO_SCROLL_EN adds a periodic self-advance.
module scroll_char_feeder #(
  parameter logic [63:0] MSG_INIT    = 64'h0123456789ABCDEF,
  parameter int          SCAN_DIV    = 16,
  parameter int          DEAD        = 2,
  parameter int          AUTO_PERIOD = 1024
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       button,
  output logic [3:0] an,
  output logic [3:0] char,
  output logic       frame_start,
  output logic [3:0] ptr
);

  localparam int PW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;

  if (SCAN_DIV < DEAD + 2 || DEAD < 1 || AUTO_PERIOD < 2) begin : g_bad_param
    $error("scroll_char_feeder: illegal SCAN_DIV/DEAD/AUTO_PERIOD combination");
  end

  logic [3:0] w_msg [16];
  for (genvar gi = 0; gi < 16; gi++) begin : g_msg
    assign w_msg[gi] = MSG_INIT[63-4*gi -: 4];
  end

  logic [PW-1:0] r_ph;
  logic [1:0]    r_s;
  logic [3:0]    r_dptr;
  logic          r_btn_q;
  logic [3:0]    r_an;
  logic [3:0]    r_char;
  logic          r_fs;
  logic [3:0]    r_ptr;

  logic [PW-1:0] w_ph_nx;
  logic [1:0]    w_s_nx;
  logic          w_ph_wrap;
  logic          w_frame;
  logic [3:0]    w_idx;
  logic          w_step;
  logic          w_adv;

  // All decisions look at the next phase/slot so the registered outputs line up with them.
  assign w_ph_wrap = (r_ph == PW'(SCAN_DIV - 1));
  assign w_ph_nx   = w_ph_wrap ? '0 : r_ph + PW'(1);
  assign w_s_nx    = w_ph_wrap ? r_s + 2'd1 : r_s;
  assign w_frame   = w_ph_wrap && (w_s_nx == 2'd0);
  assign w_idx     = (w_frame ? r_ptr : r_dptr) + {2'b00, w_s_nx};
  assign w_step    = button & ~r_btn_q;

`ifdef AUTO_SCROLL_EN
  localparam int AW = (AUTO_PERIOD > 1) ? $clog2(AUTO_PERIOD) : 1;
  logic [AW-1:0] r_auto;
  logic          w_auto_wrap;

  assign w_auto_wrap = (r_auto == AW'(AUTO_PERIOD - 1));
  assign w_adv       = w_step | w_auto_wrap;

  // A press restarts the auto interval so the two sources never stack up.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset)                     r_auto <= '0;
    else if (w_step || w_auto_wrap) r_auto <= '0;
    else                            r_auto <= r_auto + AW'(1);
  end
`else
  assign w_adv = w_step;
`endif

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_ph    <= '0;
      r_s     <= 2'd0;
      r_dptr  <= 4'h0;
      r_btn_q <= 1'b0;
      r_an    <= 4'b1111;
      r_char  <= 4'h0;
      r_fs    <= 1'b0;
      r_ptr   <= 4'h0;
    end else begin
      r_ph    <= w_ph_nx;
      r_s     <= w_s_nx;
      r_btn_q <= button;
      r_fs    <= w_frame;
      r_an    <= (w_ph_nx < PW'(DEAD)) ? 4'b1111 : ~(4'b1000 >> w_s_nx);
      if (w_frame)   r_dptr <= r_ptr;
      if (w_ph_wrap) r_char <= w_msg[w_idx];
      if (w_adv)     r_ptr  <= r_ptr + 4'h1;
    end
  end

  assign an          = r_an;
  assign char        = r_char;
  assign frame_start = r_fs;
  assign ptr         = r_ptr;

endmodule

// File: tb/tb_scroll_char_feeder.sv
// Directed bench for scroll_char_feeder: a cycle model pushes expected outputs to a queue,
// popped and compared against the DUT one cycle later.
module tb_scroll_char_feeder;
  localparam int SD = 8;
  localparam int DD = 2;
  localparam int AP = 64;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic       button = 1'b0;
  logic [3:0] an, char, ptr;
  logic       frame_start;

  scroll_char_feeder #(
    .MSG_INIT(64'h0123456789ABCDEF), .SCAN_DIV(SD), .DEAD(DD), .AUTO_PERIOD(AP)
  ) dut (
    .clk(clk), .reset(reset), .button(button),
    .an(an), .char(char), .frame_start(frame_start), .ptr(ptr)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [3:0] an;
    logic [3:0] ch;
    logic       fs;
    logic [3:0] ptr;
  } exp_t;

  exp_t       q[$];
  int         n_chk = 0;
  int         n_err = 0;
  int         cyc;
  int         m_auto;
  logic [3:0] m_ptr, m_dptr;
  logic       m_btnq;

  task automatic chk(input string tag, input logic [3:0] obs, input logic [3:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s cyc=%0d observed=%h expected=%h", tag, cyc, obs, exp);
    end
  endtask

  task automatic model_reset();
    cyc = 0; m_ptr = 4'h0; m_dptr = 4'h0; m_btnq = 1'b0; m_auto = 0;
  endtask

  task automatic chk_reset_vals(input string tag);
    chk({tag, "_an"}, an, 4'b1111);
    chk({tag, "_char"}, char, 4'h0);
    chk({tag, "_fs"}, {3'b000, frame_start}, 4'h0);
    chk({tag, "_ptr"}, ptr, 4'h0);
  endtask

  // One clock with button level b; message char i equals i for the default message.
  task automatic tick(input logic b);
    exp_t       e;
    logic       stp, wr;
    int         ph, s;
    logic [3:0] one;
    one    = 4'b1000;
    button = b;
    stp    = b & ~m_btnq;
    m_btnq = b;
    wr     = 1'b0;
`ifdef AUTO_SCROLL_EN
    wr = (m_auto == AP - 1);
`endif
    m_auto = (stp || wr) ? 0 : m_auto + 1;
    cyc++;
    ph = cyc % SD;
    s  = (cyc / SD) % 4;
    if (ph == 0 && s == 0) m_dptr = m_ptr;
    if (stp || wr) m_ptr = m_ptr + 4'h1;
    e.an  = (ph < DD) ? 4'b1111 : ~(one >> s);
    e.ch  = m_dptr + 4'(s);
    e.fs  = (ph == 0 && s == 0);
    e.ptr = m_ptr;
    q.push_back(e);
    @(posedge clk);
    @(negedge clk);
    e = q.pop_front();
    chk("an", an, e.an);
    chk("char", char, e.ch);
    chk("frame_start", {3'b000, frame_start}, {3'b000, e.fs});
    chk("ptr", ptr, e.ptr);
  endtask

  initial begin
    model_reset();
    repeat (3) @(negedge clk);
    chk_reset_vals("rst");
    reset = 1'b1;

`ifdef AUTO_SCROLL_EN
    repeat (130) tick(1'b0);
    chk("auto_two", ptr, 4'h2);
    while (m_auto != 60) tick(1'b0);
    tick(1'b1);
    chk("auto_press", ptr, 4'h3);
    repeat (63) tick(1'b0);
    chk("auto_restart_hold", ptr, 4'h3);
    tick(1'b0);
    chk("auto_restart_adv", ptr, 4'h4);
`else
    repeat (32) tick(1'b0);
    chk("frame_pulse", {3'b000, frame_start}, 4'h1);
    repeat (12) tick(1'b0);
    tick(1'b1);
    chk("press_ptr", ptr, 4'h1);
    while (cyc != 72) tick(1'b0);
    chk("new_window_slot1", char, 4'h2);
    repeat (14) begin
      tick(1'b1);
      tick(1'b0);
    end
    chk("ptr_f", ptr, 4'hF);
    tick(1'b0);
    while (cyc % 32 != 0) tick(1'b0);
    chk("wrap_slot0", char, 4'hF);
    repeat (8) tick(1'b0);
    chk("wrap_slot1", char, 4'h0);
    tick(1'b1);
    tick(1'b0);
    chk("ptr_wrap0", ptr, 4'h0);
    repeat (100) tick(1'b1);
    tick(1'b0);
    chk("held_once", ptr, 4'h1);
`endif

    // Reset mid-operation at slot 2, phase 5, with the button held through reset.
    while (cyc % 32 != 21) tick(1'b0);
    button = 1'b1;
    #2 reset = 1'b0;
    #1 chk_reset_vals("async_rst");
    @(negedge clk);
    model_reset();
    chk_reset_vals("rst_hold");
    reset = 1'b1;
    tick(1'b1);
    chk("rel_step", ptr, 4'h1);
    chk("rel_blank", an, 4'b1111);
    tick(1'b1);
    chk("rel_an3", an, 4'b0111);
    repeat (40) tick(1'b0);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end
endmodule
